deconv_output_streamer: RTL and testbench

Downstream stage of the 2D transposed-convolution core. Captures the parallel (N·K)×(N·K) output feature map when the core pulses `done`, then serializes it in raster order over a valid/ready stream with end-of-line and end-of-frame markers. Decouples the core's single-cycle result from a slower consumer: memory writer, DMA or next layer.

---
 rtl/deconv_output_streamer.sv | 173 +++++++++++++++++
 tb/tb_deconv_output_streamer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deconv_output_streamer.sv
// deconv_output_streamer
// ----------------------
// Captures the full (N*K)x(N*K) output feature map from the transposed-
// convolution core on its one-cycle `done_in` pulse. It then replays the map
// pixel by pixel, in raster order, over a valid/ready stream. Each pixel
// carries end-of-line and end-of-frame markers.
//
// Ports:
//   clk            rising-edge clock for all state
//   rst            asynchronous, active-low reset (asserted when 0)
//   done_in        one-cycle pulse; frame_in is valid in that cycle
//   frame_in       GRID*GRID pixels, row-major, index 0 is top-left
//   out_data       current pixel (registered)
//   out_valid      out_data / out_eol / out_last are valid
//   out_ready      consumer accepts the pixel when high together with out_valid
//   out_eol        current pixel is the last of its row
//   out_last       current pixel is the last of the frame
//   busy           a frame is held or being streamed
//   overrun        sticky; a frame arrived while busy and was dropped
//   clear_overrun  synchronous clear of overrun (a same-cycle set wins)
module deconv_output_streamer #(
  parameter int N           = 2,
  parameter int K           = 3,
  parameter int PIXEL_WIDTH = 8,
  parameter int GRID        = N * K
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   done_in,
  input  logic [PIXEL_WIDTH-1:0] frame_in [GRID*GRID],
  output logic [PIXEL_WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_eol,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   clear_overrun
);

  localparam int TOTAL = GRID * GRID;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CW    = (GRID > 1) ? $clog2(GRID) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TOTAL - 1);
  localparam logic [CW-1:0]    COL_MAX = CW'(GRID - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [CW-1:0]          row_reg, row_next;
  logic [CW-1:0]          col_reg, col_next;
  logic [PIXEL_WIDTH-1:0] data_reg, data_next;
  logic                   eol_reg, eol_next;
  logic                   last_reg, last_next;
  logic                   overrun_reg, overrun_next;
  logic [PIXEL_WIDTH-1:0] bank_reg [TOTAL];

  logic             handshake;
  logic             at_last;
  logic             capture;
  logic             drop;
  logic [IDX_W-1:0] idx_inc;

  // out_valid is exactly "in STREAM", so the handshake needs only the state.
  assign handshake = (state_reg == STREAM) && out_ready;
  assign at_last   = (row_reg == COL_MAX) && (col_reg == COL_MAX);
  // A new frame is accepted when idle, or when it lands on the final
  // handshake of the current frame (seamless back-to-back streaming).
  assign capture   = done_in && ((state_reg == IDLE) || (handshake && at_last));
  // Only a STREAM-state pulse can fail to be captured.
  assign drop      = done_in && !capture;
  assign idx_inc   = idx_reg + 1'b1;

  // Frame register bank: loaded only on an accepted capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TOTAL; i++) begin
        bank_reg[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < TOTAL; i++) begin
        bank_reg[i] <= frame_in[i];
      end
    end
  end

  // State and registered-output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      data_reg    <= '0;
      eol_reg     <= 1'b0;
      last_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      row_reg     <= row_next;
      col_reg     <= col_next;
      data_reg    <= data_next;
      eol_reg     <= eol_next;
      last_reg    <= last_next;
      overrun_reg <= overrun_next;
    end
  end

  // Next-state and next-output logic. The outputs are computed one cycle
  // ahead so that out_data already shows the new pixel right after the edge
  // that accepted the previous one. A captured frame's first pixel comes
  // straight from frame_in because the bank is not yet written.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    data_next    = data_reg;
    eol_next     = eol_reg;
    last_next    = last_reg;
    overrun_next = overrun_reg;

    // A set event outranks a simultaneous clear.
    if (drop) begin
      overrun_next = 1'b1;
    end else if (clear_overrun) begin
      overrun_next = 1'b0;
    end

    if (capture) begin
      state_next = STREAM;
      idx_next   = '0;
      row_next   = '0;
      col_next   = '0;
      data_next  = frame_in[0];
      eol_next   = (COL_MAX == '0);
      last_next  = (IDX_MAX == '0);
    end else if (handshake) begin
      if (at_last) begin
        state_next = IDLE;
        idx_next   = '0;
        row_next   = '0;
        col_next   = '0;
        eol_next   = 1'b0;
        last_next  = 1'b0;
      end else begin
        idx_next  = idx_inc;
        data_next = bank_reg[idx_inc];
        if (col_reg == COL_MAX) begin
          col_next = '0;
          row_next = row_reg + 1'b1;
        end else begin
          col_next = col_reg + 1'b1;
        end
        eol_next  = (col_next == COL_MAX);
        last_next = (idx_inc == IDX_MAX);
      end
    end
  end

  assign out_data  = data_reg;
  assign out_valid = (state_reg == STREAM);
  assign out_eol   = eol_reg;
  assign out_last  = last_reg;
  assign busy      = (state_reg == STREAM);
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_deconv_output_streamer.sv
// Testbench for deconv_output_streamer (N=2, K=3, 6x6 grid, 8-bit pixels).
// Every pixel the bench hands to the DUT is queued with its expected
// eol/last markers. A monitor pops and compares one entry for every accepted
// output beat. The scenario tasks also check status, latency and stability.
module tb_deconv_output_streamer;

  localparam int GRID  = 6;
  localparam int TOTAL = GRID * GRID;
  localparam int PW    = 8;

  typedef struct packed {
    logic [PW-1:0] data;
    logic          eol;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          done_in;
  logic [PW-1:0] frame_in [TOTAL];
  logic [PW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_eol;
  logic          out_last;
  logic          busy;
  logic          overrun;
  logic          clear_overrun;

  beat_t sb[$];
  int    cmp_count = 0;
  int    err_count = 0;

  deconv_output_streamer #(
    .N(2),
    .K(3),
    .PIXEL_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .done_in(done_in),
    .frame_in(frame_in),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_eol(out_eol),
    .out_last(out_last),
    .busy(busy),
    .overrun(overrun),
    .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: one line per accepted beat.
  beat_t got_b, exp_b;
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      got_b.data = out_data;
      got_b.eol  = out_eol;
      got_b.last = out_last;
      cmp_count++;
      if (sb.size() == 0) begin
        err_count++;
        $display("FAIL beat_unexpected: got data=%0d eol=%0b last=%0b, required no beat",
                 got_b.data, got_b.eol, got_b.last);
      end else begin
        exp_b = sb.pop_front();
        if (got_b !== exp_b) begin
          err_count++;
          $display("FAIL beat: got data=%0d eol=%0b last=%0b, required data=%0d eol=%0b last=%0b",
                   got_b.data, got_b.eol, got_b.last, exp_b.data, exp_b.eol, exp_b.last);
        end else begin
          $display("beat data=%0d eol=%0b last=%0b", got_b.data, got_b.eol, got_b.last);
        end
      end
    end
  end

  // Load frame base+i, queue expectations, pulse done_in over one edge.
  // Returns 1 time unit after the capturing edge.
  task automatic send_frame(input int base);
    beat_t b;
    for (int i = 0; i < TOTAL; i++) begin
      frame_in[i] = PW'(base + i);
      b.data = PW'(base + i);
      b.eol  = ((i % GRID) == GRID - 1);
      b.last = (i == TOTAL - 1);
      sb.push_back(b);
    end
    $display("capture frame base=%0d", base);
    done_in = 1'b1;
    @(posedge clk);
    #1;
    done_in = 1'b0;
    for (int i = 0; i < TOTAL; i++) frame_in[i] = 8'hEE;
  endtask

  // Drive a frame that must be dropped (nothing queued).
  task automatic send_dropped(input int base);
    for (int i = 0; i < TOTAL; i++) frame_in[i] = PW'(base + i);
    $display("drop frame base=%0d", base);
    done_in = 1'b1;
    @(posedge clk);
    #1;
    done_in = 1'b0;
    for (int i = 0; i < TOTAL; i++) frame_in[i] = 8'hEE;
  endtask

  // Bounded wait for the stream to finish and the scoreboard to empty.
  task automatic drain_wait(input string name, input int limit);
    int n = 0;
    while ((busy || sb.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    cmp_count++;
    if (busy || sb.size() != 0) begin
      err_count++;
      $display("FAIL %s_drain: got busy=%0b pending=%0d, required busy=0 pending=0",
               name, busy, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    cmp_count++;
    if ({out_valid, out_data, out_eol, out_last, busy, overrun} !== 13'b0) begin
      err_count++;
      $display("FAIL reset_outputs: got valid=%0b data=%0d eol=%0b last=%0b busy=%0b ovr=%0b, required all 0",
               out_valid, out_data, out_eol, out_last, busy, overrun);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cmp_count++;
    if (out_valid !== 1'b0) begin
      err_count++;
      $display("FAIL reset_idle: got valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_single_frame();
    int valid_cycles;
    out_ready = 1'b1;
    send_frame(1);
    cmp_count++;
    if ({out_valid, out_data} !== {1'b1, 8'd1}) begin
      err_count++;
      $display("FAIL single_latency: got valid=%0b data=%0d, required valid=1 data=1",
               out_valid, out_data);
    end
    valid_cycles = 1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
      valid_cycles++;
    end
    cmp_count++;
    if (valid_cycles != TOTAL) begin
      err_count++;
      $display("FAIL single_cycles: got %0d busy cycles, required %0d", valid_cycles, TOTAL);
    end
    cmp_count++;
    if (sb.size() != 0 || overrun !== 1'b0 || out_valid !== 1'b0) begin
      err_count++;
      $display("FAIL single_end: got pending=%0d ovr=%0b valid=%0b, required 0/0/0",
               sb.size(), overrun, out_valid);
    end
  endtask

  task automatic test_backpressure();
    bit held = 0;
    out_ready = 1'b0;
    send_frame(1);
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
      if (!held && out_data === 8'd18) begin
        out_ready = 1'b0;
        for (int h = 0; h < 5; h++) begin
          @(posedge clk);
          #1;
          cmp_count++;
          if (out_valid !== 1'b1 || out_data !== 8'd18) begin
            err_count++;
            $display("FAIL bp_hold: got valid=%0b data=%0d, required valid=1 data=18",
                     out_valid, out_data);
          end
        end
        held = 1;
        out_ready = 1'b1;
      end else begin
        out_ready = ~out_ready;
      end
    end
    cmp_count++;
    if (busy || sb.size() != 0 || !held) begin
      err_count++;
      $display("FAIL bp_complete: got busy=%0b pending=%0d held=%0b, required 0/0/1",
               busy, sb.size(), held);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    bit found = 0;
    out_ready = 1'b1;
    send_frame(1);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid && out_last) begin
        found = 1;
        break;
      end
    end
    cmp_count++;
    if (!found) begin
      err_count++;
      $display("FAIL b2b_last: got no last beat, required one within 100 cycles");
    end else begin
      send_frame(100);
      cmp_count++;
      if ({out_valid, out_data} !== {1'b1, 8'd100}) begin
        err_count++;
        $display("FAIL b2b_nobubble: got valid=%0b data=%0d, required valid=1 data=100",
                 out_valid, out_data);
      end
    end
    drain_wait("b2b", 100);
    cmp_count++;
    if (overrun !== 1'b0) begin
      err_count++;
      $display("FAIL b2b_overrun: got %0b, required 0", overrun);
    end
  endtask

  task automatic test_overrun();
    bit found = 0;
    out_ready = 1'b1;
    send_frame(1);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid && out_data === 8'd11) begin
        found = 1;
        break;
      end
    end
    cmp_count++;
    if (!found) begin
      err_count++;
      $display("FAIL ovr_find: got no pixel 11, required one within 100 cycles");
    end else begin
      send_dropped(200);
      cmp_count++;
      if (overrun !== 1'b1) begin
        err_count++;
        $display("FAIL ovr_set: got %0b, required 1", overrun);
      end
    end
    drain_wait("ovr_a", 100);
    cmp_count++;
    if (overrun !== 1'b1) begin
      err_count++;
      $display("FAIL ovr_sticky: got %0b, required 1", overrun);
    end
    clear_overrun = 1'b1;
    @(posedge clk);
    #1;
    clear_overrun = 1'b0;
    cmp_count++;
    if (overrun !== 1'b0) begin
      err_count++;
      $display("FAIL ovr_clear: got %0b, required 0", overrun);
    end
    // Simultaneous set and clear: set wins.
    send_frame(1);
    found = 0;
    for (int c = 0; c < 100; c++) begin
      if (out_data === 8'd5) begin
        found = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < TOTAL; i++) frame_in[i] = PW'(200 + i);
    done_in = 1'b1;
    clear_overrun = 1'b1;
    @(posedge clk);
    #1;
    done_in = 1'b0;
    clear_overrun = 1'b0;
    cmp_count++;
    if (overrun !== 1'b1 || !found) begin
      err_count++;
      $display("FAIL ovr_set_vs_clear: got ovr=%0b reached=%0b, required ovr=1 reached=1",
               overrun, found);
    end
    drain_wait("ovr_b", 100);
    clear_overrun = 1'b1;
    @(posedge clk);
    #1;
    clear_overrun = 1'b0;
  endtask

  task automatic test_reset_midstream();
    bit found = 0;
    int valid_seen = 0;
    out_ready = 1'b1;
    send_frame(1);
    for (int c = 0; c < 100; c++) begin
      if (out_data === 8'd21) begin
        found = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    cmp_count++;
    if ({out_valid, out_data, out_eol, out_last, busy, overrun} !== 13'b0 || !found) begin
      err_count++;
      $display("FAIL midreset_outputs: got valid=%0b data=%0d eol=%0b last=%0b busy=%0b ovr=%0b reached=%0b, required all 0 reached=1",
               out_valid, out_data, out_eol, out_last, busy, overrun, found);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) valid_seen++;
    end
    cmp_count++;
    if (valid_seen != 0) begin
      err_count++;
      $display("FAIL midreset_quiet: got %0d valid cycles, required 0", valid_seen);
    end
    @(posedge clk);
    #1;
    send_frame(1);
    cmp_count++;
    if ({out_valid, out_data} !== {1'b1, 8'd1}) begin
      err_count++;
      $display("FAIL midreset_restart: got valid=%0b data=%0d, required valid=1 data=1",
               out_valid, out_data);
    end
    drain_wait("midreset", 100);
  endtask

  initial begin
    rst           = 1'b0;
    done_in       = 1'b0;
    out_ready     = 1'b0;
    clear_overrun = 1'b0;
    for (int i = 0; i < TOTAL; i++) frame_in[i] = '0;

    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_midstream();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
